// File: rtl/ram_read_arbiter.sv
// Round-robin arbiter sharing one pipelined RAM read port among N_REQ requesters.
// A config change costs one bubble cycle; responses return in issue order.
module ram_read_arbiter #(
  parameter int N_REQ      = 4,
  parameter int RD_LATENCY = 2,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 20,
  parameter int ID_W       = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [3*N_REQ-1:0]      cfg_i,
  input  logic [ADDR_W*N_REQ-1:0] addr_i,
  output logic [N_REQ-1:0]        ack_o,
  output logic                    re_o,
  output logic [2:0]              cfg_o,
  output logic [ADDR_W-1:0]       addr_o,
  input  logic [DATA_W-1:0]       rddata_i,
  output logic                    rsp_valid_o,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic [DATA_W-1:0]       rsp_data_o,
  output logic                    rsp_err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWITCH,
    S_ISSUE
  } state_t;

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
    logic            err;
  } ent_t;

  state_t state_q, state_d;

  logic [ID_W-1:0]   ptr_q, win_q, win, idx;
  logic [ID_W-1:0]   sel_id, ack_id_q, id_d;
  logic              found, in_switch;
  logic              go_issue, go_switch;
  logic [2:0]        sel_cfg, cfg_d;
  logic [ADDR_W-1:0] sel_addr, addr_d;
  logic [N_REQ-1:0]  elig, ack_d;
  logic              re_d;

  ent_t [RD_LATENCY-1:0] pipe_q;
  ent_t                  push, head;

  // The requester being acked this cycle still holds req; mask it out.
  always_comb begin
    elig  = req_i & ~ack_o;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ID_W'((int'(ptr_q) + i) % N_REQ);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    in_switch = (state_q == S_SWITCH);
    sel_id    = in_switch ? win_q : win;
    sel_cfg   = cfg_i[int'(sel_id)*3 +: 3];
    sel_addr  = addr_i[int'(sel_id)*ADDR_W +: ADDR_W];
    go_issue  = in_switch ? req_i[sel_id]
              : found && (sel_cfg == 3'd0 ||
                          sel_cfg == cfg_o);
    go_switch = !in_switch && found &&
                sel_cfg != 3'd0 &&
                sel_cfg != cfg_o;
  end

  always_comb begin
    state_d = S_IDLE;
    unique case (1'b1)
      go_issue:  state_d = S_ISSUE;
      go_switch: state_d = S_SWITCH;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack_d  = '0;
    re_d   = 1'b0;
    id_d   = ack_id_q;
    addr_d = addr_o;
    cfg_d  = cfg_o;
    if (go_issue) begin
      ack_d[sel_id] = 1'b1;
      re_d          = (sel_cfg != 3'd0);
      addr_d        = sel_addr;
      id_d          = sel_id;
    end
    if (go_switch) cfg_d = sel_cfg;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      ack_o    <= '0;
      re_o     <= 1'b0;
      addr_o   <= '0;
      cfg_o    <= '0;
      ack_id_q <= '0;
    end else begin
      state_q  <= state_d;
      ack_o    <= ack_d;
      re_o     <= re_d;
      addr_o   <= addr_d;
      cfg_o    <= cfg_d;
      ack_id_q <= id_d;
      if (go_switch) win_q <= win;
      if (go_issue)
        ptr_q <= ID_W'((int'(sel_id) + 1) % N_REQ);
    end
  end

  // An ack with re_o low is an invalid-config request.
  always_comb begin
    push.v   = |ack_o;
    push.id  = ack_id_q;
    push.err = |ack_o & ~re_o;
    head     = pipe_q[RD_LATENCY-1];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pipe_q      <= '0;
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= '0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      for (int i = RD_LATENCY-1; i > 0; i--)
        pipe_q[i] <= pipe_q[i-1];
      pipe_q[0]   <= push;
      rsp_valid_o <= head.v;
      rsp_err_o   <= head.v & head.err;
      if (head.v) begin
        rsp_id_o   <= head.id;
        rsp_data_o <= head.err ? '0 : rddata_i;
      end
    end
  end

endmodule
